// File: rtl/mcu_spi.sv
// SPI slave front end for the external MCU: oversamples mode-0 SPI in clk,
// routes received bytes to the on-chip targets and returns target data on MISO.
//
//   state      | meaning
//   ST_TARGET  | next complete byte selects the target
//   ST_COMMAND | next complete byte is the command byte (strobed with mcu_start)
//   ST_DATA    | payload bytes; MISO returns the selected target's data_out

module mcu_spi #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din,
  input  logic [7:0] mcu_sdc_din
);

  typedef enum logic [1:0] {ST_TARGET, ST_COMMAND, ST_DATA} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_pipe;
  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] din_pipe;
  logic                   sck_prev;
  logic [2:0]             bit_cnt;
  logic [7:0]             target;
  logic [6:0]             mosi_sr;
  logic [6:0]             miso_sr;

  logic       ss_s;
  logic       sck_s;
  logic       din_s;
  logic       sck_rise;
  logic       sck_fall;
  logic       target_ok;
  logic [7:0] rx_byte;
  logic [7:0] sel_din;
  logic [7:0] miso_load;

  assign ss_s      = ss_pipe[SYNC_STAGES-1];
  assign sck_s     = sck_pipe[SYNC_STAGES-1];
  assign din_s     = din_pipe[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  assign rx_byte   = {mosi_sr, din_s};
  assign target_ok = (target >= 8'd1) && (target <= 8'd4);

  always_comb begin
    sel_din = 8'h00;
    case (target)
      8'd1:    sel_din = mcu_sys_din;
      8'd2:    sel_din = mcu_hid_din;
      8'd3:    sel_din = mcu_osd_din;
      8'd4:    sel_din = mcu_sdc_din;
      default: sel_din = 8'h00;
    endcase
  end

  // Target and command bytes always return zeros on MISO.
  assign miso_load = (state == ST_DATA) ? sel_din : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_pipe        <= '1;
      sck_pipe       <= '0;
      din_pipe       <= '0;
      sck_prev       <= 1'b0;
      state          <= ST_TARGET;
      bit_cnt        <= 3'd0;
      target         <= 8'h00;
      mosi_sr        <= 7'h00;
      miso_sr        <= 7'h00;
      spi_io_dout    <= 1'b0;
      mcu_start      <= 1'b0;
      mcu_dout       <= 8'h00;
      mcu_sys_strobe <= 1'b0;
      mcu_hid_strobe <= 1'b0;
      mcu_osd_strobe <= 1'b0;
      mcu_sdc_strobe <= 1'b0;
    end else begin
      ss_pipe        <= {ss_pipe[SYNC_STAGES-2:0], spi_io_ss};
      sck_pipe       <= {sck_pipe[SYNC_STAGES-2:0], spi_io_clk};
      din_pipe       <= {din_pipe[SYNC_STAGES-2:0], spi_io_din};
      sck_prev       <= sck_s;
      mcu_start      <= 1'b0;
      mcu_sys_strobe <= 1'b0;
      mcu_hid_strobe <= 1'b0;
      mcu_osd_strobe <= 1'b0;
      mcu_sdc_strobe <= 1'b0;

      // Idle has priority so an SS rise coinciding with the 8th SCK rise drops the byte.
      if (ss_s) begin
        state       <= ST_TARGET;
        bit_cnt     <= 3'd0;
        target      <= 8'h00;
        mosi_sr     <= 7'h00;
        miso_sr     <= 7'h00;
        spi_io_dout <= 1'b0;
      end else begin
        if (sck_rise) begin
          mosi_sr <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == ST_TARGET) begin
              target <= rx_byte;
              state  <= ST_COMMAND;
            end else begin
              state <= ST_DATA;
              if (target_ok) begin
                mcu_dout       <= rx_byte;
                mcu_start      <= (state == ST_COMMAND);
                mcu_sys_strobe <= (target == 8'd1);
                mcu_hid_strobe <= (target == 8'd2);
                mcu_osd_strobe <= (target == 8'd3);
                mcu_sdc_strobe <= (target == 8'd4);
              end
            end
          end
        end

        if (sck_fall) begin
          if (bit_cnt != 3'd0) begin
            spi_io_dout <= miso_sr[6];
            miso_sr     <= {miso_sr[5:0], 1'b0};
          end else begin
            spi_io_dout <= miso_load[7];
            miso_sr     <= miso_load[6:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mcu_spi.sv
// Directed bench for mcu_spi: drives MCU SPI frames, scoreboards target strobes
// and checks returned MISO bytes against models of the stub targets.

module tb_mcu_spi;

  localparam int SYNC = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_io_ss;
  logic       spi_io_clk;
  logic       spi_io_din;
  logic       spi_io_dout;
  logic       mcu_start;
  logic [7:0] mcu_dout;
  logic       mcu_sys_strobe;
  logic       mcu_hid_strobe;
  logic       mcu_osd_strobe;
  logic       mcu_sdc_strobe;
  logic [7:0] mcu_sys_din = 8'hA5;
  logic [7:0] mcu_hid_din = 8'hC3;
  logic [7:0] mcu_osd_din = 8'h99;
  logic [7:0] mcu_sdc_din = 8'hE7;

  mcu_spi #(.SYNC_STAGES(SYNC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_io_ss      (spi_io_ss),
    .spi_io_clk     (spi_io_clk),
    .spi_io_din     (spi_io_din),
    .spi_io_dout    (spi_io_dout),
    .mcu_start      (mcu_start),
    .mcu_dout       (mcu_dout),
    .mcu_sys_strobe (mcu_sys_strobe),
    .mcu_hid_strobe (mcu_hid_strobe),
    .mcu_osd_strobe (mcu_osd_strobe),
    .mcu_sdc_strobe (mcu_sdc_strobe),
    .mcu_sys_din    (mcu_sys_din),
    .mcu_hid_din    (mcu_hid_din),
    .mcu_osd_din    (mcu_osd_din),
    .mcu_sdc_din    (mcu_sdc_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sys_pat(input int idx);
    if (idx == 0) return 8'h5C;
    if (idx == 1) return 8'h42;
    return 8'h00;
  endfunction

  // Stub targets: each updates data_out one clk after its strobe.
  int sys_idx = 0;
  always @(posedge clk) begin
    if (mcu_sys_strobe) begin
      if (mcu_start) begin
        mcu_sys_din <= 8'h00;
        sys_idx     <= 0;
      end else begin
        mcu_sys_din <= sys_pat(sys_idx);
        sys_idx     <= sys_idx + 1;
      end
    end
    if (mcu_hid_strobe) mcu_hid_din <= ~mcu_dout;
    if (mcu_osd_strobe) mcu_osd_din <= mcu_dout + 8'd1;
    if (mcu_sdc_strobe) mcu_sdc_din <= mcu_dout ^ 8'h5A;
  end

  typedef struct {
    logic [2:0] tgt;
    logic       start;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] frame_q[$];
  logic [7:0] model_val[8];
  int         model_sys_idx = 0;
  int         checks = 0;
  int         errors = 0;
  int         lo_clk = 6;
  int         hi_clk = 6;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [7:0] t, input logic st, input logic [7:0] d);
    case (t)
      8'd1: begin
        if (st) begin
          model_val[1]  = 8'h00;
          model_sys_idx = 0;
        end else begin
          model_val[1]  = sys_pat(model_sys_idx);
          model_sys_idx = model_sys_idx + 1;
        end
      end
      8'd2: model_val[2] = ~d;
      8'd3: model_val[3] = d + 8'd1;
      8'd4: model_val[4] = d ^ 8'h5A;
      default: ;
    endcase
  endtask

  task automatic push_exp(input logic [7:0] t, input logic st, input logic [7:0] d);
    exp_t e;
    e.tgt   = t[2:0];
    e.start = st;
    e.data  = d;
    sb.push_back(e);
  endtask

  // Sends the top n bits of b MSB first; MISO is sampled just before each SCK fall.
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_io_din = b[i];
      repeat (lo_clk) @(negedge clk);
      spi_io_clk = 1'b1;
      repeat (hi_clk) @(negedge clk);
      miso[i]    = spi_io_dout;
      spi_io_clk = 1'b0;
    end
  endtask

  task automatic run_frame();
    logic [7:0] miso;
    logic [7:0] tgt;
    logic [7:0] exp_miso;
    logic       valid;
    spi_io_ss = 1'b0;
    repeat (4) @(negedge clk);
    tgt   = frame_q[0];
    valid = (tgt >= 8'd1) && (tgt <= 8'd4);
    for (int k = 0; k < frame_q.size(); k++) begin
      exp_miso = (k >= 2 && valid) ? model_val[tgt[2:0]] : 8'h00;
      if (k >= 1 && valid) push_exp(tgt, k == 1, frame_q[k]);
      send_bits(frame_q[k], 8, miso);
      check($sformatf("miso_t%0h_b%0d", tgt, k), 32'(miso), 32'(exp_miso));
      if (k >= 1 && valid) model_update(tgt, k == 1, frame_q[k]);
    end
    repeat (8) @(negedge clk);
    spi_io_ss = 1'b1;
    repeat (8) @(negedge clk);
    check("strobes_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic strobe_monitor();
    exp_t       e;
    logic [3:0] s;
    forever begin
      @(negedge clk);
      s = {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe};
      if (reset_n && s != 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(s), 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_sel", 32'(s), 32'(4'b0001 << (e.tgt - 3'd1)));
          check("strobe_start", 32'(mcu_start), 32'(e.start));
          check("strobe_dout", 32'(mcu_dout), 32'(e.data));
        end
      end else if (reset_n) begin
        check("start_idle", 32'(mcu_start), 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] miso;
    for (int i = 0; i < 8; i++) model_val[i] = 8'h00;
    reset_n    = 1'b0;
    spi_io_ss  = 1'b1;
    spi_io_clk = 1'b0;
    spi_io_din = 1'b0;
    fork
      strobe_monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(spi_io_dout), 32'd0);
    check("rst_start", 32'(mcu_start), 32'd0);
    check("rst_mcu_dout", 32'(mcu_dout), 32'd0);
    check("rst_strobes", 32'({mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe}), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // sysctrl frame with readback pattern
    frame_q = {8'h01, 8'h00, 8'hAA, 8'hAA, 8'hAA};
    run_frame();

    // sysctrl color command
    frame_q = {8'h01, 8'h02, 8'h12, 8'h34, 8'h56};
    run_frame();

    // non-existent target: no strobes, MISO zero
    frame_q = {8'h07, 8'h11, 8'h22, 8'h33};
    run_frame();

    // SS rises after 5 bits of byte 3
    spi_io_ss = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h03, 8, miso);
    push_exp(8'h03, 1'b1, 8'h11);
    send_bits(8'h11, 8, miso);
    push_exp(8'h03, 1'b0, 8'h22);
    send_bits(8'h22, 8, miso);
    model_update(8'h03, 1'b1, 8'h11);
    model_update(8'h03, 1'b0, 8'h22);
    send_bits(8'h33, 5, miso);
    repeat (2) @(negedge clk);
    spi_io_ss = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_drained", 32'(sb.size()), 32'd0);
    frame_q = {8'h03, 8'h05};
    run_frame();

    // SS rise in the same clk as the 8th SCK rise drops the byte
    spi_io_ss = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h02, 8, miso);
    push_exp(8'h02, 1'b1, 8'h10);
    send_bits(8'h10, 8, miso);
    model_update(8'h02, 1'b1, 8'h10);
    send_bits(8'h77, 7, miso);
    spi_io_din = 1'b1;
    repeat (lo_clk) @(negedge clk);
    spi_io_clk = 1'b1;
    spi_io_ss  = 1'b1;
    repeat (hi_clk) @(negedge clk);
    spi_io_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("race_drained", 32'(sb.size()), 32'd0);

    // asynchronous reset mid-byte
    spi_io_ss = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h04, 8, miso);
    push_exp(8'h04, 1'b1, 8'h81);
    send_bits(8'h81, 8, miso);
    push_exp(8'h04, 1'b0, 8'hC0);
    send_bits(8'hC0, 8, miso);
    model_update(8'h04, 1'b1, 8'h81);
    model_update(8'h04, 1'b0, 8'hC0);
    send_bits(8'hFF, 3, miso);
    repeat (5) @(negedge clk);
    check("pre_rst_miso", 32'(spi_io_dout), 32'd1);
    check("pre_rst_mcu_dout", 32'(mcu_dout), 32'hC0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(spi_io_dout), 32'd0);
    check("async_rst_mcu_dout", 32'(mcu_dout), 32'd0);
    check("async_rst_start", 32'(mcu_start), 32'd0);
    check("async_rst_strobes", 32'({mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe}), 32'd0);
    @(negedge clk);
    spi_io_ss  = 1'b1;
    spi_io_clk = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    frame_q = {8'h04, 8'h01};
    run_frame();

    // fast SCK (clk/4), random 64-byte frame to HID
    lo_clk  = 2;
    hi_clk  = 2;
    frame_q = {8'h02};
    for (int i = 0; i < 64; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    run_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
